// File: rtl/acc_sequencer.sv
// Accumulator execute sequencer: one instruction per 3 cycles (IDLE -> READ -> EXEC)
// against a register file with one-cycle registered read data.
//
// state | meaning
// IDLE  | ready for an instruction; latch it and its address on accept
// READ  | address stable, register file captures R[a]
// EXEC  | read data valid; ACC/flags/ERR update, ST writes, DONE raised
module acc_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RF_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [7:0]        INSTR,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic              RF_CE,
  output logic [DATA_W-1:0] RF_DATA_IN,
  input  logic [DATA_W-1:0] RF_DATA_OUT,
  output logic [DATA_W-1:0] ACC,
  output logic              FLAG_Z,
  output logic              FLAG_C,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC} state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;

  state_t      state;
  logic [7:0]  instr_q;
  logic [3:0]  op;
  logic [3:0]  arg;
  logic        addr_ok;
  logic        illegal;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] acc_nxt;
  logic        c_nxt;
  logic        z_nxt;
  logic        upd_z;

  assign op      = instr_q[7:4];
  assign arg     = instr_q[3:0];
  assign addr_ok = int'(arg) < RF_DEPTH;

  always_comb begin
    illegal = 1'b1;
    case (op)
      OP_NOP, OP_LDI: illegal = 1'b0;
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: illegal = !addr_ok;
      default: illegal = 1'b1;
    endcase
  end

  // Borrow on SUB falls out as the top bit of the widened difference.
  assign sum  = {1'b0, ACC} + {1'b0, RF_DATA_OUT};
  assign diff = {1'b0, ACC} - {1'b0, RF_DATA_OUT};

  always_comb begin
    acc_nxt = ACC;
    c_nxt   = FLAG_C;
    upd_z   = 1'b0;
    if (!illegal) begin
      case (op)
        OP_LD:  begin acc_nxt = RF_DATA_OUT; upd_z = 1'b1; end
        OP_ADD: begin acc_nxt = sum[DATA_W-1:0]; c_nxt = sum[DATA_W]; upd_z = 1'b1; end
        OP_SUB: begin acc_nxt = diff[DATA_W-1:0]; c_nxt = diff[DATA_W]; upd_z = 1'b1; end
        OP_AND: begin acc_nxt = ACC & RF_DATA_OUT; c_nxt = 1'b0; upd_z = 1'b1; end
        OP_OR:  begin acc_nxt = ACC | RF_DATA_OUT; c_nxt = 1'b0; upd_z = 1'b1; end
        OP_XOR: begin acc_nxt = ACC ^ RF_DATA_OUT; c_nxt = 1'b0; upd_z = 1'b1; end
        OP_LDI: begin acc_nxt = {{(DATA_W-4){1'b0}}, arg}; upd_z = 1'b1; end
        default: ;
      endcase
    end
    z_nxt = upd_z ? (acc_nxt == '0) : FLAG_Z;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      instr_q <= '0;
      RF_ADDR <= '0;
      ACC     <= '0;
      FLAG_Z  <= 1'b0;
      FLAG_C  <= 1'b0;
      ERR     <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) begin
            instr_q <= INSTR;
            RF_ADDR <= ADDR_W'(INSTR[3:0]);
            state   <= S_READ;
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          ACC    <= acc_nxt;
          FLAG_Z <= z_nxt;
          FLAG_C <= c_nxt;
          if (illegal) ERR <= 1'b1;
          DONE   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write strobe is gated by reset so an aborted ST never reaches the register file.
  assign RF_CE       = (state == S_EXEC) && (op == OP_ST) && !illegal && !RST;
  assign INSTR_READY = (state == S_IDLE);
  assign RF_DATA_IN  = ACC;

endmodule
